// File: rtl/intra_frame_queue_if.sv
// Purpose: loader, release and intra-fetch signals between the frame store and its neighbours.
// Ports: pixel loader (pix_*), frame status (data_ready, load_overrun, frame_release),
//        fetch handshake (inq_addr, inq_update, MB_ready, MB_flat) and debug state.
interface intra_frame_queue_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        load_overrun;
  logic        frame_release;
  logic        data_ready;
  logic [14:0] inq_addr;
  logic        inq_update;
  logic        MB_ready;
  logic [31:0] MB_flat;
  logic [1:0]  debug_status_queue;

  // master: loader / control / intra requester side
  modport master (
    output pix_data, pix_valid, frame_release, inq_addr, inq_update,
    input  pix_ready, load_overrun, data_ready, MB_ready, MB_flat, debug_status_queue
  );

  // slave: the frame store itself
  modport slave (
    input  pix_data, pix_valid, frame_release, inq_addr, inq_update,
    output pix_ready, load_overrun, data_ready, MB_ready, MB_flat, debug_status_queue
  );
endinterface

// File: rtl/intra_frame_queue.sv
// Purpose: 256x256 8-bit luma frame store, filled in raster order, serving 2x2-pixel quads.
// Latency: a fetch accepted at edge N returns MB_flat with MB_ready=1 after edge N+1+RD_LAT.
// Backpressure: pix_ready=0 while a full frame is held (pixels dropped, load_overrun sticky);
//               a new fetch needs inq_update to have been sampled low since the last one.
// Ports: clk, rst (async active-high), bus (intra_frame_queue_if.slave).
module intra_frame_queue #(
  parameter int RD_LAT = 1  // frame RAM read latency, 1 or 2
) (
  input  logic               clk,
  input  logic               rst,
  intra_frame_queue_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  localparam logic WAIT_LAST = (RD_LAT == 2) ? 1'b1 : 1'b0;

  // 16384 words, one 2x2 quad per word
  logic [31:0] mem [0:16383];

  logic [15:0] pix_cnt;       // {y, x} of the next pixel to accept
  logic        data_ready_q;
  logic        overrun_q;
  logic        pix_acc;
  logic [13:0] wr_addr;
  logic [1:0]  wr_lane;

  logic [1:0]  state;
  logic        armed;
  logic [13:0] rd_addr;
  logic        wait_cnt;
  logic [31:0] ram_q;
  logic [31:0] ram_q2;
  logic [31:0] rd_data;
  logic [31:0] flat_q;

  logic        unused_addr_msb;
  assign unused_addr_msb = bus.inq_addr[14];

  assign pix_acc = bus.pix_valid & ~data_ready_q;
  // word = {y[7:1], x[7:1]}, lane = {y[0], x[0]}
  assign wr_addr = {pix_cnt[15:9], pix_cnt[7:1]};
  assign wr_lane = {pix_cnt[8], pix_cnt[0]};

  // Loader and frame-held status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt      <= 16'd0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (pix_acc)
        pix_cnt <= pix_cnt + 16'd1;
      if (bus.pix_valid && data_ready_q)
        overrun_q <= 1'b1;
      // Last pixel takes priority; release only acts on a held frame anyway.
      if (pix_acc && (pix_cnt == 16'hFFFF))
        data_ready_q <= 1'b1;
      else if (bus.frame_release && data_ready_q)
        data_ready_q <= 1'b0;
    end
  end

  // Frame RAM: byte-lane writes, registered read with optional second stage.
  // Read-during-write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (pix_acc)
      mem[wr_addr][{wr_lane, 3'b000} +: 8] <= bus.pix_data;
    ram_q  <= mem[rd_addr];
    ram_q2 <= ram_q;
  end

  assign rd_data = (RD_LAT == 2) ? ram_q2 : ram_q;

  // Read FSM. armed re-arms whenever the request level is seen low, so a level
  // held across a finished response never triggers a second fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      armed    <= 1'b1;
      rd_addr  <= 14'd0;
      wait_cnt <= 1'b0;
      flat_q   <= 32'd0;
    end else begin
      if (!bus.inq_update)
        armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (armed && bus.inq_update) begin
            rd_addr  <= bus.inq_addr[13:0];
            armed    <= 1'b0;
            wait_cnt <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST)
            state <= S_RESP;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        S_RESP: begin
          flat_q <= rd_data;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.MB_ready           = (state == S_IDLE);
  assign bus.MB_flat            = flat_q;
  assign bus.debug_status_queue = state;
  assign bus.data_ready         = data_ready_q;
  assign bus.pix_ready          = ~data_ready_q;
  assign bus.load_overrun       = overrun_q;

endmodule

// File: tb/tb_intra_frame_queue.sv
module tb_intra_frame_queue;

  logic clk = 1'b0;
  logic rst1;
  logic rst2;
  always #5 clk = ~clk;

  intra_frame_queue_if b1 ();
  intra_frame_queue_if b2 ();

  intra_frame_queue #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
  intra_frame_queue #(.RD_LAT(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

  int vectors = 0;
  int miscompares = 0;

  // Reference frame per DUT, indexed by raster position y*256+x
  logic [7:0] model [2][65536];
  int cnt1 = 0;

  // Count fetches on dut1 as falling edges of MB_ready
  int   falls1 = 0;
  logic prev1  = 1'b1;
  always @(negedge clk) begin
    if (prev1 === 1'b1 && b1.MB_ready === 1'b0) falls1++;
    prev1 = b1.MB_ready;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_quad(input int d, input logic [14:0] a);
    int x, y;
    x = 2 * int'(a[6:0]);
    y = 2 * int'(a[13:7]);
    return {model[d][(y+1)*256 + x + 1], model[d][(y+1)*256 + x],
            model[d][y*256 + x + 1],     model[d][y*256 + x]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read1(input logic [14:0] a, output logic [31:0] d, output int low);
    b1.inq_addr   = a;
    b1.inq_update = 1'b1;
    tick();
    b1.inq_update = 1'b0;
    low = 0;
    while (b1.MB_ready !== 1'b1 && low < 16) begin
      low++;
      tick();
    end
    d = b1.MB_flat;
  endtask

  task automatic read2(input logic [14:0] a, output logic [31:0] d, output int low);
    b2.inq_addr   = a;
    b2.inq_update = 1'b1;
    tick();
    b2.inq_update = 1'b0;
    low = 0;
    while (b2.MB_ready !== 1'b1 && low < 16) begin
      low++;
      tick();
    end
    d = b2.MB_flat;
  endtask

  task automatic test_reset();
    logic [38:0] obs, exp;
    exp = {1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00};
    obs = {b1.MB_ready, b1.MB_flat, b1.data_ready, b1.pix_ready, b1.load_overrun, b1.debug_status_queue};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_dut1: got %h expected %h", obs, exp); end
    obs = {b2.MB_ready, b2.MB_flat, b2.data_ready, b2.pix_ready, b2.load_overrun, b2.debug_status_queue};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_dut2: got %h expected %h", obs, exp); end
  endtask

  // dut1: ramp at one pixel per cycle. dut2: random frame with random bubbles and
  // stray release pulses, with a release forced onto its final pixel.
  task automatic test_parallel_load();
    int i1, i2, cyc;
    bit v2;
    logic [7:0] d2;
    i1 = 0; i2 = 0; cyc = 0;
    while ((i1 < 65536 || i2 < 65536) && cyc < 90000) begin
      if (i1 < 65536) begin
        b1.pix_valid = 1'b1;
        b1.pix_data  = 8'((i1 % 256) + 3 * (i1 / 256));
      end else begin
        b1.pix_valid = 1'b0;
      end
      v2 = (i2 < 65536) && ($urandom_range(7) != 0);
      d2 = 8'($urandom);
      b2.pix_valid = v2;
      b2.pix_data  = d2;
      b2.frame_release = (v2 && i2 == 65535) ? 1'b1 :
                         ((i2 < 65536) && ($urandom_range(31) == 0));
      tick();
      cyc++;
      if (i1 < 65536) begin
        model[0][i1] = 8'((i1 % 256) + 3 * (i1 / 256));
        i1++;
      end
      if (v2) begin
        model[1][i2] = d2;
        i2++;
      end
      vectors++;
      if (b1.data_ready !== (i1 == 65536) || b1.pix_ready !== (i1 != 65536)) begin
        miscompares++;
        $display("FAIL load_status_dut1 px%0d: got dr=%b pr=%b expected dr=%b", i1, b1.data_ready, b1.pix_ready, i1 == 65536);
      end
      vectors++;
      if (b2.data_ready !== (i2 == 65536) || b2.pix_ready !== (i2 != 65536)) begin
        miscompares++;
        $display("FAIL load_status_dut2 px%0d: got dr=%b pr=%b expected dr=%b", i2, b2.data_ready, b2.pix_ready, i2 == 65536);
      end
    end
    b1.pix_valid = 1'b0;
    b2.pix_valid = 1'b0;
    b2.frame_release = 1'b0;
    cnt1 = 0;
    vectors++;
    if (cyc >= 90000) begin miscompares++; $display("FAIL load_budget: got %0d cycles expected under 90000", cyc); end
    vectors++;
    if (b1.load_overrun !== 1'b0 || b2.load_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL load_no_overrun: got %b/%b expected 0/0", b1.load_overrun, b2.load_overrun);
    end
  endtask

  task automatic test_known_quads();
    logic [31:0] d;
    int low;
    read1(15'h0000, d, low);
    vectors++;
    if (d !== 32'h04030100) begin miscompares++; $display("FAIL quad_0000: got %h expected 04030100", d); end
    vectors++;
    if (low !== 2) begin miscompares++; $display("FAIL latency_rdlat1: got %0d expected 2", low); end
    vectors++;
    if (b1.data_ready !== 1'b1) begin miscompares++; $display("FAIL data_ready_held: got %b expected 1", b1.data_ready); end
    read1(15'h0105, d, low);
    vectors++;
    if (d !== 32'h1A191716) begin miscompares++; $display("FAIL quad_0105: got %h expected 1A191716", d); end
    read1(15'h7FFF, d, low);
    vectors++;
    if (d !== 32'hFCFBF9F8) begin miscompares++; $display("FAIL quad_7FFF: got %h expected FCFBF9F8", d); end
  endtask

  task automatic test_random_reads();
    logic [31:0] d;
    logic [14:0] a;
    int low;
    for (int k = 0; k < 16; k++) begin
      a = 15'($urandom);
      read1(a, d, low);
      vectors++;
      if (d !== exp_quad(0, a) || low !== 2) begin
        miscompares++;
        $display("FAIL rand_read_dut1 %h: got %h lat %0d expected %h lat 2", a, d, low, exp_quad(0, a));
      end
      a = 15'($urandom);
      read2(a, d, low);
      vectors++;
      if (d !== exp_quad(1, a) || low !== 3) begin
        miscompares++;
        $display("FAIL rand_read_dut2 %h: got %h lat %0d expected %h lat 3", a, d, low, exp_quad(1, a));
      end
    end
  endtask

  task automatic test_handshake();
    logic [14:0] base, a;
    int f0, n;
    base = 15'($urandom) & 15'h7F7E;
    f0 = falls1;
    for (int k = 0; k < 4; k++) begin
      a = base | {7'd0, 1'(k >> 1), 6'd0, 1'(k)};
      b1.inq_addr   = a;
      b1.inq_update = 1'b1;
      n = 0;
      do begin tick(); n++; end while (b1.MB_ready !== 1'b0 && n < 16);
      tick();
      b1.inq_update = 1'b0;
      while (b1.MB_ready !== 1'b1 && n < 32) begin tick(); n++; end
      vectors++;
      if (b1.MB_flat !== exp_quad(0, a) || n >= 32) begin
        miscompares++;
        $display("FAIL handshake_sb%0d: got %h expected %h", k, b1.MB_flat, exp_quad(0, a));
      end
    end
    tick(); tick();
    vectors++;
    if (falls1 - f0 !== 4) begin miscompares++; $display("FAIL handshake_fetch_count: got %0d expected 4", falls1 - f0); end
    // A level held far past one response must produce exactly one fetch
    a = 15'($urandom);
    f0 = falls1;
    b1.inq_addr   = a;
    b1.inq_update = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    vectors++;
    if (falls1 - f0 !== 1 || b1.MB_ready !== 1'b1 || b1.MB_flat !== exp_quad(0, a)) begin
      miscompares++;
      $display("FAIL held_level: got fetches %0d rdy %b data %h expected 1 1 %h", falls1 - f0, b1.MB_ready, b1.MB_flat, exp_quad(0, a));
    end
    b1.inq_update = 1'b0;
    tick();
  endtask

  task automatic test_overrun_release();
    logic [31:0] d;
    int low;
    b1.pix_valid = 1'b1;
    b1.pix_data  = 8'hEE;
    for (int k = 0; k < 3; k++) tick();
    b1.pix_valid = 1'b0;
    vectors++;
    if (b1.load_overrun !== 1'b1 || b1.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flag: got ovr %b dr %b expected 1 1", b1.load_overrun, b1.data_ready);
    end
    read1(15'h0000, d, low);
    vectors++;
    if (d !== 32'h04030100) begin miscompares++; $display("FAIL overrun_ram_kept: got %h expected 04030100", d); end
    b1.frame_release = 1'b1;
    tick();
    b1.frame_release = 1'b0;
    vectors++;
    if (b1.data_ready !== 1'b0 || b1.pix_ready !== 1'b1 || b1.load_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL release: got dr %b pr %b ovr %b expected 0 1 1", b1.data_ready, b1.pix_ready, b1.load_overrun);
    end
    // Ten 0xAA pixels must land at the frame start: overrun left the counter alone
    b1.pix_valid = 1'b1;
    b1.pix_data  = 8'hAA;
    for (int k = 0; k < 10; k++) begin tick(); model[0][cnt1] = 8'hAA; cnt1++; end
    b1.pix_valid = 1'b0;
    read1(15'h0000, d, low);
    vectors++;
    if (d !== 32'h0403AAAA) begin miscompares++; $display("FAIL partial_reload: got %h expected 0403AAAA", d); end
    // Mid-load reset: counter returns to pixel (0,0)
    rst1 = 1'b1;
    #1;
    vectors++;
    if ({b1.MB_ready, b1.MB_flat, b1.data_ready, b1.load_overrun} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_load: got rdy %b flat %h dr %b ovr %b expected 1 0 0 0", b1.MB_ready, b1.MB_flat, b1.data_ready, b1.load_overrun);
    end
    tick();
    rst1 = 1'b0;
    cnt1 = 0;
    b1.pix_valid = 1'b1;
    b1.pix_data  = 8'h55;
    for (int k = 0; k < 258; k++) begin tick(); model[0][cnt1] = 8'h55; cnt1++; end
    b1.pix_valid = 1'b0;
    read1(15'h0000, d, low);
    vectors++;
    if (d !== 32'h55555555) begin miscompares++; $display("FAIL const_quad: got %h expected 55555555", d); end
    read1(15'h0001, d, low);
    vectors++;
    if (d !== exp_quad(0, 15'h0001)) begin miscompares++; $display("FAIL mixed_quad: got %h expected %h", d, exp_quad(0, 15'h0001)); end
    vectors++;
    if (b1.data_ready !== 1'b0) begin miscompares++; $display("FAIL partial_not_ready: got %b expected 0", b1.data_ready); end
  endtask

  task automatic test_simul_release();
    vectors++;
    if (b2.data_ready !== 1'b1 || b2.pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_release: got dr %b pr %b expected 1 0", b2.data_ready, b2.pix_ready);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] d;
    logic [14:0] a;
    int low, tries;
    tries = 0;
    do begin a = 15'($urandom); tries++; end while (exp_quad(1, a) == 32'd0 && tries < 50);
    read2(a, d, low);
    vectors++;
    if (d !== exp_quad(1, a)) begin miscompares++; $display("FAIL pre_reset_read: got %h expected %h", d, exp_quad(1, a)); end
    b2.inq_addr   = 15'($urandom);
    b2.inq_update = 1'b1;
    tick();
    b2.inq_update = 1'b0;
    vectors++;
    if (b2.debug_status_queue !== 2'b01 || b2.MB_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_wait: got st %b rdy %b expected 01 0", b2.debug_status_queue, b2.MB_ready);
    end
    rst2 = 1'b1;
    #1;
    vectors++;
    if ({b2.MB_ready, b2.MB_flat, b2.data_ready, b2.debug_status_queue} !== {1'b1, 32'd0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got rdy %b flat %h dr %b st %b expected 1 0 0 00", b2.MB_ready, b2.MB_flat, b2.data_ready, b2.debug_status_queue);
    end
    tick();
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (b2.MB_ready !== 1'b1 || b2.MB_flat !== 32'd0) begin
      miscompares++;
      $display("FAIL dropped_request: got rdy %b flat %h expected 1 0", b2.MB_ready, b2.MB_flat);
    end
    a = 15'($urandom);
    read2(a, d, low);
    vectors++;
    if (d !== exp_quad(1, a) || low !== 3) begin
      miscompares++;
      $display("FAIL post_reset_read: got %h lat %0d expected %h lat 3", d, low, exp_quad(1, a));
    end
  endtask

  initial begin
    rst1 = 1'b1;
    rst2 = 1'b1;
    b1.pix_data = 8'd0; b1.pix_valid = 1'b0; b1.frame_release = 1'b0;
    b1.inq_addr = 15'd0; b1.inq_update = 1'b0;
    b2.pix_data = 8'd0; b2.pix_valid = 1'b0; b2.frame_release = 1'b0;
    b2.inq_addr = 15'd0; b2.inq_update = 1'b0;
    tick(); tick();
    test_reset();
    rst1 = 1'b0;
    rst2 = 1'b0;
    tick();
    test_parallel_load();
    test_known_quads();
    test_random_reads();
    test_handshake();
    test_overrun_release();
    test_simul_release();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
